// File: rtl/ram1_arb_pkg.sv
// Shared constants for the RAM1 arbiter: FSM encoding and default timing.
package ram1_arb_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] RD_DONE = 3'd2;
  localparam logic [2:0] WS      = 3'd3;
  localparam logic [2:0] WP      = 3'd4;
  localparam logic [2:0] WH      = 3'd5;

  localparam int unsigned DEF_ADDR_W       = 18;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_RD_CYCLES    = 2;
  localparam int unsigned DEF_WE_CYCLES    = 1;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram1_arb_priority.sv
// Grant decision between IF and MEM with a saturating IF starvation counter.
module ram1_arb_priority
  import ram1_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic if_req,
  input  logic mem_req,
  input  logic gnt_stb,
  output logic grant_if,
  output logic grant_mem
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          at_limit;

  // MEM normally wins; IF wins once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    at_limit  = (starve_q == LIMIT);
    grant_if  = gnt_stb & if_req & (~mem_req | at_limit);
    grant_mem = gnt_stb & mem_req & ~(if_req & at_limit);
    starve_d  = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem && if_req && !at_limit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ram1_arbiter.sv
// Shares the RAM1 SRAM port between IF reads and MEM reads/writes,
// sequencing the OE/WE/EN waveforms and returning a one-cycle ack.
module ram1_arbiter
  import ram1_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned RD_CYCLES    = DEF_RD_CYCLES,
  parameter int unsigned WE_CYCLES    = DEF_WE_CYCLES,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              RAM1OE,
  output logic              RAM1WE,
  output logic              RAM1EN,
  output logic [ADDR_W-1:0] RAM1ADDR,
  inout  wire  [DATA_W-1:0] RAM1DATA
);

  localparam int unsigned MAXC = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
  localparam int unsigned CW   = cnt_width(MAXC);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic               sel_if_q, sel_if_d;
  logic               oe_q, oe_d, we_q, we_d, en_q, en_d;
  logic               drive_q, drive_d;
  logic               if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic               busy_q, busy_d;
  logic               grant_if, grant_mem;

  ram1_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .CLK      (CLK),
    .RST      (RST),
    .if_req   (if_req),
    .mem_req  (mem_req),
    .gnt_stb  (state_q == IDLE),
    .grant_if (grant_if),
    .grant_mem(grant_mem)
  );

  // Next-state and next-output decode; every pin value is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_if_d    = sel_if_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    oe_d        = 1'b1;
    we_d        = 1'b1;
    en_d        = en_q;
    drive_d     = 1'b0;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = 1'b1;
        if (grant_if || grant_mem) begin
          en_d     = 1'b0;
          sel_if_d = grant_if;
          cnt_d    = '0;
          addr_d   = grant_if ? if_addr : mem_addr;
          if (grant_mem && mem_we) begin
            wdata_d = mem_wdata;
            drive_d = 1'b1;
            state_d = WS;
          end else begin
            oe_d    = 1'b0;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt_q == CW'(RD_CYCLES - 1)) begin
          state_d = RD_DONE;
          cnt_d   = '0;
          if (sel_if_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = RAM1DATA;
          end else begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = RAM1DATA;
          end
        end else begin
          oe_d  = 1'b0;
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_DONE: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
      WS: begin
        drive_d = 1'b1;
        we_d    = 1'b0;
        state_d = WP;
      end
      WP: begin
        drive_d = 1'b1;
        if (cnt_q == CW'(WE_CYCLES - 1)) begin
          mem_ack_d = 1'b1;
          cnt_d     = '0;
          state_d   = WH;
        end else begin
          we_d  = 1'b0;
          cnt_d = cnt_q + CW'(1);
        end
      end
      WH: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset releases the bus asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_if_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      en_q        <= 1'b1;
      drive_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_if_q    <= sel_if_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      en_q        <= en_d;
      drive_q     <= drive_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;
  assign RAM1OE    = oe_q;
  assign RAM1WE    = we_q;
  assign RAM1EN    = en_q;
  assign RAM1ADDR  = addr_q;
  assign RAM1DATA  = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
